// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: bundle of the signals between the SPI byte slave, the
// command controller, the frame-buffer write port, the control-register bank
// and the buffer-swap logic.
//   spi_addr/spi_data/spi_first/spi_last/spi_stb : SPI transaction bytes (to controller)
//   spi_out                                      : status byte for readback (from controller)
//   fb_addr/fb_data/fb_valid, fb_ready           : frame-buffer write handshake
//   reg_idx/reg_val/reg_we                       : control-register write
//   swap_req, swap_ack                           : buffer-swap handshake
// Modports: master = environment side, slave = spi_cmd_ctrl side.
interface spi_cmd_ctrl_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [7:0]        spi_addr;
  logic [7:0]        spi_data;
  logic              spi_first;
  logic              spi_last;
  logic              spi_stb;
  logic [7:0]        spi_out;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic              fb_valid;
  logic              fb_ready;
  logic [3:0]        reg_idx;
  logic [7:0]        reg_val;
  logic              reg_we;
  logic              swap_req;
  logic              swap_ack;

  modport master (
    output spi_addr, spi_data, spi_first, spi_last, spi_stb, fb_ready, swap_ack,
    input  spi_out, fb_addr, fb_data, fb_valid, reg_idx, reg_val, reg_we, swap_req
  );

  modport slave (
    input  spi_addr, spi_data, spi_first, spi_last, spi_stb, fb_ready, swap_ack,
    output spi_out, fb_addr, fb_data, fb_valid, reg_idx, reg_val, reg_we, swap_req
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes SPI transactions (command byte + data bytes) into
// control-register writes, auto-incrementing frame-buffer pixel writes through
// a small FIFO, buffer-swap requests and a registered status byte.
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   bus        spi_cmd_ctrl_if.slave (SPI bytes in, status out, fb/reg/swap ports)
// Parameters: ADDR_W (frame-buffer address width, > 8), FIFO_DEPTH (power of two, >= 2).
// Build option: define SPI_CMD_CTRL_ADDR_WRAP_EN to let the frame-buffer
// address wrap from all-ones to zero; otherwise bytes past the top address
// are dropped and flagged as an error.
module spi_cmd_ctrl #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  spi_cmd_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef SPI_CMD_CTRL_ADDR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [3:0] CMD_NOP  = 4'h0;
  localparam logic [3:0] CMD_REG  = 4'h1;
  localparam logic [3:0] CMD_FB   = 4'h2;
  localparam logic [3:0] CMD_SWAP = 4'h3;
  localparam logic [3:0] CMD_CLR  = 4'h4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } fb_entry_t;

  // Each state names the byte the controller is waiting for next.
  typedef enum logic [2:0] {
    IDLE, REG_IDX, REG_VAL, FB_AHI, FB_ALO, FB_DATA, IGNORE
  } state_t;

  state_t            state_q, state_d, byte_state;
  logic              last_q;
  logic [3:0]        wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              addr_end_q, addr_end_d;
  logic [3:0]        reg_idx_q, reg_idx_d;
  logic [7:0]        reg_val_q, reg_val_d;
  logic              reg_we_q, reg_we_d;
  logic              ovf_q, ovf_d, err_q, err_d;
  logic              swap_pend_q, swap_pend_d;
  logic              swap_req_q, swap_req_d;
  logic [7:0]        spi_out_q, spi_out_d;
  fb_entry_t         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fb_valid_q, fb_valid_d;

  logic              last_rise, push, push_ok, pop, full;
  logic              ovf_set, err_set, clr;
  logic [3:0]        occ;
  fb_entry_t         push_entry;
  logic              unused_cmd_lo;

  assign unused_cmd_lo = ^bus.spi_addr[3:0];

  // Next-state, byte handling, FIFO control and status composition.
  always_comb begin
    state_d     = state_q;
    byte_state  = state_q;
    wr_idx_d    = wr_idx_q;
    wr_addr_d   = wr_addr_q;
    addr_end_d  = addr_end_q;
    reg_idx_d   = reg_idx_q;
    reg_val_d   = reg_val_q;
    reg_we_d    = 1'b0;
    swap_pend_d = swap_pend_q;
    swap_req_d  = swap_req_q;
    push        = 1'b0;
    push_entry  = '{addr: wr_addr_q, data: bus.spi_data};
    ovf_set     = 1'b0;
    err_set     = 1'b0;
    clr         = 1'b0;
    last_rise   = bus.spi_last & ~last_q;
    full        = (count_q == CNT_W'(FIFO_DEPTH));
    pop         = fb_valid_q & bus.fb_ready;

    if (bus.spi_stb) begin
      // A first-byte strobe re-decodes; its byte is then handled as byte 0.
      if (bus.spi_first) begin
        case (bus.spi_addr[7:4])
          CMD_NOP: byte_state = IDLE;
          CMD_REG: byte_state = REG_IDX;
          CMD_FB:  byte_state = FB_AHI;
          CMD_SWAP: begin
            byte_state = IDLE;
            if (swap_req_q) err_set = 1'b1;
            else            swap_pend_d = 1'b1;
          end
          CMD_CLR: begin
            byte_state = IDLE;
            clr        = 1'b1;
          end
          default: begin
            byte_state = IGNORE;
            err_set    = 1'b1;
          end
        endcase
      end
      state_d = byte_state;
      case (byte_state)
        REG_IDX: begin
          wr_idx_d = bus.spi_data[3:0];
          state_d  = REG_VAL;
        end
        REG_VAL: begin
          reg_idx_d = wr_idx_q;
          reg_val_d = bus.spi_data;
          reg_we_d  = 1'b1;
          wr_idx_d  = wr_idx_q + 4'd1;
        end
        FB_AHI: begin
          wr_addr_d  = ADDR_W'({bus.spi_data, 8'h00});
          addr_end_d = 1'b0;
          state_d    = FB_ALO;
        end
        FB_ALO: begin
          wr_addr_d  = (wr_addr_q & ~ADDR_W'(8'hFF)) | ADDR_W'(bus.spi_data);
          addr_end_d = 1'b0;
          state_d    = FB_DATA;
        end
        FB_DATA: begin
          if (addr_end_q) begin
            err_set = 1'b1;
            state_d = IGNORE;
          end else begin
            push       = 1'b1;
            wr_addr_d  = wr_addr_q + ADDR_W'(1);
            // Without wrap, the top address ends the writable range.
            addr_end_d = (&wr_addr_q) & ~WRAP_EN;
          end
        end
        default: ;
      endcase
    end

    if (last_rise && !(bus.spi_stb && bus.spi_first)) state_d = IDLE;

    if (swap_req_q && bus.swap_ack) begin
      swap_req_d  = 1'b0;
      swap_pend_d = 1'b0;
    end else if (last_rise && swap_pend_q) begin
      swap_req_d = 1'b1;
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = push & (~full | pop);
    if (push && !push_ok) ovf_set = 1'b1;
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    fb_valid_d = (count_d != '0);

    // Set beats clear when both happen in one cycle.
    ovf_d = (ovf_q & ~clr) | ovf_set;
    err_d = (err_q & ~clr) | err_set;

    occ       = (32'(count_d) > 32'd15) ? 4'hF : 4'(count_d);
    spi_out_d = {swap_req_d, fb_valid_d, ovf_d, err_d, occ};
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      wr_idx_q    <= '0;
      wr_addr_q   <= '0;
      addr_end_q  <= 1'b0;
      reg_idx_q   <= '0;
      reg_val_q   <= '0;
      reg_we_q    <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_req_q  <= 1'b0;
      spi_out_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fb_valid_q  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= bus.spi_last;
      wr_idx_q    <= wr_idx_d;
      wr_addr_q   <= wr_addr_d;
      addr_end_q  <= addr_end_d;
      reg_idx_q   <= reg_idx_d;
      reg_val_q   <= reg_val_d;
      reg_we_q    <= reg_we_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      swap_pend_q <= swap_pend_d;
      swap_req_q  <= swap_req_d;
      spi_out_q   <= spi_out_d;
      count_q     <= count_d;
      fb_valid_q  <= fb_valid_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign bus.spi_out  = spi_out_q;
  assign bus.fb_addr  = mem_q[rd_ptr_q].addr;
  assign bus.fb_data  = mem_q[rd_ptr_q].data;
  assign bus.fb_valid = fb_valid_q;
  assign bus.reg_idx  = reg_idx_q;
  assign bus.reg_val  = reg_val_q;
  assign bus.reg_we   = reg_we_q;
  assign bus.swap_req = swap_req_q;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed bench for spi_cmd_ctrl (ADDR_W=14, FIFO_DEPTH=4).
// Build option SPI_CMD_CTRL_ADDR_WRAP_EN selects the expected wrap behaviour.
module tb_spi_cmd_ctrl;
  localparam int unsigned ADDR_W     = 14;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } fb_wr_t;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] val;
  } reg_wr_t;

  logic     clk = 1'b0;
  logic     rst;
  int       n_checks = 0;
  int       n_fail   = 0;
  fb_wr_t   fb_log[$];
  reg_wr_t  reg_log[$];

  spi_cmd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  spi_cmd_ctrl #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Record accepted frame-buffer writes and register write pulses.
  always @(negedge clk) begin
    if (bus.fb_valid && bus.fb_ready) fb_log.push_back('{addr: bus.fb_addr, data: bus.fb_data});
    if (bus.reg_we) reg_log.push_back('{idx: bus.reg_idx, val: bus.reg_val});
  end

  function automatic fb_wr_t fb_at(input int i);
    return (i < fb_log.size()) ? fb_log[i] : '1;
  endfunction

  function automatic reg_wr_t reg_at(input int i);
    return (i < reg_log.size()) ? reg_log[i] : '1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic first, input logic [7:0] cmd, input logic [7:0] data);
    bus.spi_stb   = 1'b1;
    bus.spi_first = first;
    bus.spi_addr  = cmd;
    bus.spi_data  = data;
    tick();
    bus.spi_stb   = 1'b0;
    bus.spi_first = 1'b0;
  endtask

  task automatic end_txn();
    bus.spi_last = 1'b1;
    tick();
    tick();
    bus.spi_last = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.spi_addr  = 8'h00;
    bus.spi_data  = 8'h00;
    bus.spi_first = 1'b0;
    bus.spi_last  = 1'b0;
    bus.spi_stb   = 1'b0;
    bus.fb_ready  = 1'b0;
    bus.swap_ack  = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.spi_out, bus.swap_req, bus.reg_we} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_status: got spi_out=%h swap_req=%b reg_we=%b, want all 0", bus.spi_out, bus.swap_req, bus.reg_we);
    end
    n_checks++;
    if ({bus.fb_valid, bus.fb_addr, bus.fb_data, bus.reg_idx, bus.reg_val} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_ports: got fb_valid=%b fb_addr=%h fb_data=%h reg_idx=%h reg_val=%h, want all 0",
               bus.fb_valid, bus.fb_addr, bus.fb_data, bus.reg_idx, bus.reg_val);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reg_write();
    reg_log.delete();
    send_byte(1'b1, 8'h10, 8'h03);
    n_checks++;
    if (bus.reg_we !== 1'b0) begin
      n_fail++; $display("FAIL reg_index_byte: got reg_we=%b, want 0", bus.reg_we);
    end
    send_byte(1'b0, 8'h10, 8'hAA);
    n_checks++;
    if ({bus.reg_we, bus.reg_idx, bus.reg_val} !== {1'b1, 4'h3, 8'hAA}) begin
      n_fail++; $display("FAIL reg_write0: got we=%b idx=%h val=%h, want 1/3/aa", bus.reg_we, bus.reg_idx, bus.reg_val);
    end
    send_byte(1'b0, 8'h10, 8'hBB);
    n_checks++;
    if ({bus.reg_we, bus.reg_idx, bus.reg_val} !== {1'b1, 4'h4, 8'hBB}) begin
      n_fail++; $display("FAIL reg_write1: got we=%b idx=%h val=%h, want 1/4/bb", bus.reg_we, bus.reg_idx, bus.reg_val);
    end
    tick();
    n_checks++;
    if ({bus.reg_we, bus.reg_idx, bus.reg_val} !== {1'b0, 4'h4, 8'hBB}) begin
      n_fail++; $display("FAIL reg_hold: got we=%b idx=%h val=%h, want 0/4/bb", bus.reg_we, bus.reg_idx, bus.reg_val);
    end
    end_txn();
    n_checks++;
    if (reg_log.size() != 2) begin
      n_fail++; $display("FAIL reg_pulse_count: got %0d, want 2", reg_log.size());
    end
    // Index wraps 15 -> 0.
    reg_log.delete();
    send_byte(1'b1, 8'h10, 8'h0F);
    send_byte(1'b0, 8'h10, 8'h01);
    send_byte(1'b0, 8'h10, 8'h02);
    tick();
    end_txn();
    n_checks++;
    if ({reg_log.size() == 2, reg_at(0), reg_at(1)} !== {1'b1, 4'hF, 8'h01, 4'h0, 8'h02}) begin
      n_fail++; $display("FAIL reg_idx_wrap: got n=%0d %h %h, want 2 f01 002", reg_log.size(), reg_at(0), reg_at(1));
    end
  endtask

  task automatic test_fb_write();
    logic [7:0] bytes [3];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bus.fb_ready = 1'b1;
    fb_log.delete();
    send_byte(1'b1, 8'h20, 8'h00);
    send_byte(1'b0, 8'h20, 8'h10);
    n_checks++;
    if (bus.fb_valid !== 1'b0) begin
      n_fail++; $display("FAIL fb_header_no_write: got fb_valid=%b, want 0", bus.fb_valid);
    end
    for (int i = 0; i < 3; i++) begin
      send_byte(1'b0, 8'h20, bytes[i]);
      n_checks++;
      if ({bus.fb_valid, bus.fb_addr, bus.fb_data} !== {1'b1, 14'(14'h0010 + i), bytes[i]}) begin
        n_fail++;
        $display("FAIL fb_head%0d: got v=%b addr=%h data=%h, want 1/%h/%h", i, bus.fb_valid, bus.fb_addr,
                 bus.fb_data, 14'(14'h0010 + i), bytes[i]);
      end
    end
    tick();
    n_checks++;
    if (bus.fb_valid !== 1'b0) begin
      n_fail++; $display("FAIL fb_drained: got fb_valid=%b, want 0", bus.fb_valid);
    end
    end_txn();
    n_checks++;
    if ({fb_log.size() == 3, fb_at(0), fb_at(1), fb_at(2)} !==
        {1'b1, 14'h0010, 8'h11, 14'h0011, 8'h22, 14'h0012, 8'h33}) begin
      n_fail++;
      $display("FAIL fb_write_log: got n=%0d %h %h %h", fb_log.size(), fb_at(0), fb_at(1), fb_at(2));
    end
  endtask

  task automatic test_fb_overflow();
    bus.fb_ready = 1'b0;
    fb_log.delete();
    send_byte(1'b1, 8'h20, 8'h01);
    send_byte(1'b0, 8'h20, 8'h00);
    for (int i = 0; i < 6; i++) send_byte(1'b0, 8'h20, 8'(8'hA0 + i));
    n_checks++;
    if (bus.spi_out !== 8'h64) begin
      n_fail++; $display("FAIL ovf_status: got spi_out=%h, want 64", bus.spi_out);
    end
    end_txn();
    n_checks++;
    if ({bus.fb_valid, bus.fb_addr, bus.fb_data, fb_log.size() == 0} !== {1'b1, 14'h0100, 8'hA0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_head_stable: got v=%b addr=%h data=%h writes=%0d, want 1/0100/a0/0",
               bus.fb_valid, bus.fb_addr, bus.fb_data, fb_log.size());
    end
    bus.fb_ready = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (fb_log.size() != 4) begin
      n_fail++; $display("FAIL ovf_write_count: got %0d, want 4", fb_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fb_at(i) !== {14'(14'h0100 + i), 8'(8'hA0 + i)}) begin
        n_fail++; $display("FAIL ovf_write%0d: got %h, want %h", i, fb_at(i), {14'(14'h0100 + i), 8'(8'hA0 + i)});
      end
    end
    n_checks++;
    if (bus.spi_out !== 8'h20) begin
      n_fail++; $display("FAIL ovf_sticky: got spi_out=%h, want 20", bus.spi_out);
    end
  endtask

  task automatic test_swap();
    send_byte(1'b1, 8'h30, 8'h00);
    n_checks++;
    if (bus.swap_req !== 1'b0) begin
      n_fail++; $display("FAIL swap_before_cs: got swap_req=%b, want 0", bus.swap_req);
    end
    bus.spi_last = 1'b1;
    tick();
    n_checks++;
    if ({bus.swap_req, bus.spi_out} !== {1'b1, 8'hA0}) begin
      n_fail++; $display("FAIL swap_on_cs: got swap_req=%b spi_out=%h, want 1/a0", bus.swap_req, bus.spi_out);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (bus.swap_req !== 1'b1) begin
        n_fail++; $display("FAIL swap_hold%0d: got swap_req=%b, want 1", i, bus.swap_req);
      end
    end
    bus.spi_last = 1'b0;
    tick();
    send_byte(1'b1, 8'h30, 8'h00);
    n_checks++;
    if ({bus.swap_req, bus.spi_out[4]} !== 2'b11) begin
      n_fail++; $display("FAIL swap_while_req: got swap_req=%b err=%b, want 1/1", bus.swap_req, bus.spi_out[4]);
    end
    bus.swap_ack = 1'b1;
    tick();
    bus.swap_ack = 1'b0;
    n_checks++;
    if (bus.swap_req !== 1'b0) begin
      n_fail++; $display("FAIL swap_ack: got swap_req=%b, want 0", bus.swap_req);
    end
    bus.spi_last = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.swap_req !== 1'b0) begin
      n_fail++; $display("FAIL swap_rejected_cmd: got swap_req=%b, want 0", bus.swap_req);
    end
    bus.spi_last = 1'b0;
    tick();
  endtask

  task automatic test_error_clear();
    send_byte(1'b1, 8'h40, 8'h00);
    n_checks++;
    if (bus.spi_out !== 8'h00) begin
      n_fail++; $display("FAIL clr_both: got spi_out=%h, want 00", bus.spi_out);
    end
    end_txn();
    bus.fb_ready = 1'b1;
    fb_log.delete();
    reg_log.delete();
    send_byte(1'b1, 8'h70, 8'h00);
    n_checks++;
    if (bus.spi_out !== 8'h10) begin
      n_fail++; $display("FAIL bad_cmd_err: got spi_out=%h, want 10", bus.spi_out);
    end
    send_byte(1'b0, 8'h70, 8'h12);
    send_byte(1'b0, 8'h70, 8'h34);
    tick();
    n_checks++;
    if ({fb_log.size() == 0, reg_log.size() == 0, bus.spi_out} !== {2'b11, 8'h10}) begin
      n_fail++;
      $display("FAIL bad_cmd_ignored: got fb=%0d reg=%0d spi_out=%h, want 0/0/10", fb_log.size(), reg_log.size(), bus.spi_out);
    end
    end_txn();
    send_byte(1'b1, 8'h40, 8'h00);
    n_checks++;
    if (bus.spi_out !== 8'h00) begin
      n_fail++; $display("FAIL clr_err: got spi_out=%h, want 00", bus.spi_out);
    end
    end_txn();
  endtask

  task automatic test_addr_wrap();
    bus.fb_ready = 1'b1;
    fb_log.delete();
    // High byte 0xFF: bits above ADDR_W are dropped, start address 0x3FFF.
    send_byte(1'b1, 8'h20, 8'hFF);
    send_byte(1'b0, 8'h20, 8'hFF);
    send_byte(1'b0, 8'h20, 8'h01);
    n_checks++;
    if ({bus.fb_valid, bus.fb_addr, bus.fb_data} !== {1'b1, 14'h3FFF, 8'h01}) begin
      n_fail++; $display("FAIL wrap_first: got v=%b addr=%h data=%h, want 1/3fff/01", bus.fb_valid, bus.fb_addr, bus.fb_data);
    end
    send_byte(1'b0, 8'h20, 8'h02);
    tick();
    tick();
`ifdef SPI_CMD_CTRL_ADDR_WRAP_EN
    n_checks++;
    if ({fb_log.size() == 2, fb_at(0), fb_at(1), bus.spi_out} !== {1'b1, 14'h3FFF, 8'h01, 14'h0000, 8'h02, 8'h00}) begin
      n_fail++;
      $display("FAIL wrap_on: got n=%0d %h %h spi_out=%h", fb_log.size(), fb_at(0), fb_at(1), bus.spi_out);
    end
`else
    n_checks++;
    if ({fb_log.size() == 1, fb_at(0), bus.spi_out} !== {1'b1, 14'h3FFF, 8'h01, 8'h10}) begin
      n_fail++;
      $display("FAIL wrap_off: got n=%0d %h spi_out=%h, want 1 3fff01 10", fb_log.size(), fb_at(0), bus.spi_out);
    end
`endif
    end_txn();
    send_byte(1'b1, 8'h40, 8'h00);
    end_txn();
  endtask

  task automatic test_async_reset();
    bus.fb_ready = 1'b0;
    send_byte(1'b1, 8'h20, 8'h00);
    send_byte(1'b0, 8'h20, 8'h20);
    send_byte(1'b0, 8'h20, 8'hC1);
    send_byte(1'b0, 8'h20, 8'hC2);
    send_byte(1'b0, 8'h20, 8'hC3);
    n_checks++;
    if ({bus.fb_valid, bus.spi_out} !== {1'b1, 8'h43}) begin
      n_fail++; $display("FAIL rst_pre_queue: got v=%b spi_out=%h, want 1/43", bus.fb_valid, bus.spi_out);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.fb_valid, bus.spi_out} !== 9'h0) begin
      n_fail++; $display("FAIL rst_immediate: got v=%b spi_out=%h, want 0/00", bus.fb_valid, bus.spi_out);
    end
    @(negedge clk);
    rst = 1'b0;
    fb_log.delete();
    bus.fb_ready = 1'b1;
    repeat (5) tick();
    n_checks++;
    if ({fb_log.size() == 0, bus.fb_valid, bus.spi_out} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_flush: got writes=%0d v=%b spi_out=%h, want 0/0/00", fb_log.size(), bus.fb_valid, bus.spi_out);
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_fb_write();
    test_fb_overflow();
    test_swap();
    test_error_clear();
    test_addr_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
